// File: rtl/coax_spi_control_pkg.sv
// Shared types and constants for the coax SPI command controller.
package coax_control_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE,
    CMD,
    TX_HI,
    TX_LO,
    RX_WORD,
    RX_LO,
    STATUS,
    DISCARD
  } state_e;

  // Default command bytes.
  localparam logic [7:0] CMD_TX_DEF     = 8'h04;
  localparam logic [7:0] CMD_RX_DEF     = 8'h05;
  localparam logic [7:0] CMD_STATUS_DEF = 8'h01;

  // Byte returned to the host when the RX FIFO had nothing to pop.
  localparam logic [7:0] EMPTY_MARK = 8'h80;

  // Bit positions inside the status byte.
  localparam int STAT_TX_FULL   = 7;
  localparam int STAT_RX_EMPTY  = 6;
  localparam int STAT_RX_ACTIVE = 5;
  localparam int STAT_TX_ACTIVE = 4;
  localparam int STAT_RX_ERR    = 3;
  localparam int STAT_TX_OVF    = 2;

endpackage

// File: rtl/coax_spi_control_if.sv
// Bus bundle between the SPI byte slave, the coax TX/RX FIFOs and the controller.
// slave  : the controller's view.
// master : the environment's view (SPI slave + FIFOs).
interface coax_spi_control_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  spi_cs;
  logic [7:0]            spi_rx_data;
  logic                  spi_rx_strobe;
  logic [7:0]            spi_tx_data;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_full;
  logic                  tx_active;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_empty;
  logic                  rx_read;
  logic                  rx_active;
  logic                  rx_error;

  modport slave (
    input  spi_cs, spi_rx_data, spi_rx_strobe,
    input  tx_full, tx_active, rx_data, rx_empty, rx_active, rx_error,
    output spi_tx_data, tx_data, tx_load, rx_read
  );

  modport master (
    output spi_cs, spi_rx_data, spi_rx_strobe,
    output tx_full, tx_active, rx_data, rx_empty, rx_active, rx_error,
    input  spi_tx_data, tx_data, tx_load, rx_read
  );
endinterface

// File: rtl/coax_spi_control.sv
// SPI command controller: decodes the frame command byte, packs byte pairs
// into DATA_WIDTH-bit TX words and unpacks RX words into byte pairs.
// Optional build macro: COAX_CONTROL_STATUS_EN enables the status command
// and the status-read clear of the sticky flags.
module coax_spi_control
  import coax_control_pkg::*;
#(
  parameter int         DATA_WIDTH = 10,
  parameter logic [7:0] CMD_TX     = CMD_TX_DEF,
  parameter logic [7:0] CMD_RX     = CMD_RX_DEF,
  parameter logic [7:0] CMD_STATUS = CMD_STATUS_DEF
) (
  input logic               clk,
  input logic               reset,
  coax_spi_control_if.slave bus
);

  state_e                state_q;
  logic [DATA_WIDTH-9:0] hi_q;       // only the bits that reach the word
  logic [7:0]            lo_q;       // low byte of the last popped word
  logic [7:0]            spi_tx_data_q;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_load_q;
  logic                  rx_read_q;
  logic                  tx_ovf_q;
  logic                  rx_err_s_q;

  // High byte of an RX word: {0, err, zero pad, upper word bits}.
  function automatic logic [7:0] rx_hi_byte(input logic [DATA_WIDTH-1:0] w,
                                            input logic err);
    logic [7:0] b;
    b = '0;
    b[6] = err;
    b[DATA_WIDTH-9:0] = w[DATA_WIDTH-1:8];
    return b;
  endfunction

  function automatic logic [7:0] status_byte(input logic err_s, input logic ovf);
    logic [7:0] b;
    b = '0;
    b[STAT_TX_FULL]   = bus.tx_full;
    b[STAT_RX_EMPTY]  = bus.rx_empty;
    b[STAT_RX_ACTIVE] = bus.rx_active;
    b[STAT_TX_ACTIVE] = bus.tx_active;
    b[STAT_RX_ERR]    = err_s;
    b[STAT_TX_OVF]    = ovf;
    return b;
  endfunction

  logic                  strobe;
  logic                  rx_err_now;
  logic [7:0]            rx_entry_byte;
  logic [DATA_WIDTH-1:0] tx_word;

  // Shared values for RX-word entry and TX word assembly.
  always_comb begin
    strobe        = bus.spi_rx_strobe;
    rx_err_now    = bus.rx_error | rx_err_s_q;
    rx_entry_byte = bus.rx_empty ? EMPTY_MARK : rx_hi_byte(bus.rx_data, rx_err_now);
    tx_word       = {hi_q, bus.spi_rx_data};
  end

`ifndef COAX_CONTROL_STATUS_EN
  // Activity flags only feed the status byte.
  logic unused_status_inputs;
  assign unused_status_inputs = bus.tx_active | bus.rx_active;
`endif

  // Frame FSM with registered outputs and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hi_q          <= '0;
      lo_q          <= 8'h00;
      spi_tx_data_q <= 8'h00;
      tx_data_q     <= '0;
      tx_load_q     <= 1'b0;
      rx_read_q     <= 1'b0;
      tx_ovf_q      <= 1'b0;
      rx_err_s_q    <= 1'b0;
    end else begin
      tx_load_q <= 1'b0;
      rx_read_q <= 1'b0;
      if (bus.spi_cs) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: state_q <= CMD;
          CMD: if (strobe) begin
            if (bus.spi_rx_data == CMD_TX) begin
              state_q <= TX_HI;
            end else if (bus.spi_rx_data == CMD_RX) begin
              state_q       <= RX_WORD;
              spi_tx_data_q <= rx_entry_byte;
              lo_q          <= bus.rx_empty ? 8'h00 : bus.rx_data[7:0];
              rx_read_q     <= ~bus.rx_empty;
`ifdef COAX_CONTROL_STATUS_EN
            end else if (bus.spi_rx_data == CMD_STATUS) begin
              state_q       <= STATUS;
              spi_tx_data_q <= status_byte(rx_err_s_q, tx_ovf_q);
`endif
            end else begin
              state_q <= DISCARD;
            end
          end
          TX_HI: if (strobe) begin
            hi_q    <= bus.spi_rx_data[DATA_WIDTH-9:0];
            state_q <= TX_LO;
          end
          TX_LO: if (strobe) begin
            if (!bus.tx_full) begin
              tx_data_q <= tx_word;
              tx_load_q <= 1'b1;
            end else begin
              tx_ovf_q <= 1'b1;
            end
            state_q <= TX_HI;
          end
          RX_WORD: if (strobe) begin
            spi_tx_data_q <= lo_q;
            state_q       <= RX_LO;
          end
          RX_LO: if (strobe) begin
            state_q       <= RX_WORD;
            spi_tx_data_q <= rx_entry_byte;
            lo_q          <= bus.rx_empty ? 8'h00 : bus.rx_data[7:0];
            rx_read_q     <= ~bus.rx_empty;
          end
`ifdef COAX_CONTROL_STATUS_EN
          STATUS: if (strobe) begin
            // A completed status read clears the flags; a same-cycle error still sets.
            tx_ovf_q      <= 1'b0;
            rx_err_s_q    <= 1'b0;
            spi_tx_data_q <= status_byte(bus.rx_error, 1'b0);
          end
`endif
          DISCARD: state_q <= DISCARD;
          default: state_q <= IDLE;
        endcase
      end
      if (bus.rx_error) rx_err_s_q <= 1'b1;
    end
  end

  assign bus.spi_tx_data = spi_tx_data_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_load     = tx_load_q;
  assign bus.rx_read     = rx_read_q;

endmodule

// File: tb/tb_coax_spi_control.sv
// Bench for coax_spi_control: directed scenarios plus randomized frames
// checked against a byte-level model of the controller's protocol.
module tb_coax_spi_control;
  import coax_control_pkg::*;

  localparam int DW = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  coax_spi_control_if #(.DATA_WIDTH(DW)) bus();

  coax_spi_control #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int load_cnt = 0;
  int read_cnt = 0;
  int exp_loads = 0;
  int exp_reads = 0;
  bit err_s_m = 1'b0;

  // Count every write/pop pulse the DUT produces.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.tx_load) load_cnt++;
      if (bus.rx_read) read_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One SPI byte: strobe for one cycle, sample outputs one cycle after, then idle a cycle.
  task automatic send(input logic [7:0] b, output logic [7:0] miso, output logic ld,
                      output logic [DW-1:0] txd, output logic rd);
    @(posedge clk); #1;
    bus.spi_rx_data   = b;
    bus.spi_rx_strobe = 1'b1;
    @(posedge clk); #1;
    bus.spi_rx_strobe = 1'b0;
    miso = bus.spi_tx_data;
    ld   = bus.tx_load;
    txd  = bus.tx_data;
    rd   = bus.rx_read;
    @(posedge clk); #1;
  endtask

  task automatic frame_start();
    @(posedge clk); #1;
    bus.spi_cs = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic frame_end();
    @(posedge clk); #1;
    bus.spi_cs = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_error();
    @(posedge clk); #1;
    bus.rx_error = 1'b1;
    @(posedge clk); #1;
    bus.rx_error = 1'b0;
    err_s_m = 1'b1;
  endtask

  function automatic logic [7:0] exp_hi(input logic [DW-1:0] w, input bit err);
    return 8'((int'(err) << 6) | (int'(w) >> 8));
  endfunction

  logic [7:0]    miso;
  logic          ld, rd;
  logic [DW-1:0] txd;
  logic [7:0]    hi, lo, cb;
  logic [DW-1:0] w;
  bit            full, empty;
  int            kind, n;

  initial begin
    bus.spi_cs = 1'b1; bus.spi_rx_data = 8'h00; bus.spi_rx_strobe = 1'b0;
    bus.tx_full = 1'b0; bus.tx_active = 1'b0; bus.rx_data = '0;
    bus.rx_empty = 1'b1; bus.rx_active = 1'b0; bus.rx_error = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_spi_tx_data", 32'(bus.spi_tx_data), 32'h00);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("rst_tx_load", 32'(bus.tx_load), 32'h0);
    check("rst_rx_read", 32'(bus.rx_read), 32'h0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;

    // TX word
    frame_start();
    send(8'h04, miso, ld, txd, rd);
    send(8'h03, miso, ld, txd, rd);
    check("tx_no_early_load", 32'(ld), 32'h0);
    send(8'hFF, miso, ld, txd, rd);
    check("tx_load", 32'(ld), 32'h1);
    check("tx_data", 32'(txd), 32'h3FF);
    exp_loads++;
    frame_end();

    // TX overflow
    bus.tx_full = 1'b1;
    frame_start();
    send(8'h04, miso, ld, txd, rd);
    send(8'h01, miso, ld, txd, rd);
    send(8'h23, miso, ld, txd, rd);
    check("ovf_no_load", 32'(ld), 32'h0);
    check("ovf_flag", 32'(dut.tx_ovf_q), 32'h1);
    frame_end();
    bus.tx_full = 1'b0;
`ifdef COAX_CONTROL_STATUS_EN
    frame_start();
    send(8'h01, miso, ld, txd, rd);
    check("status_first", 32'(miso), 32'h44);
    send(8'h00, miso, ld, txd, rd);
    check("status_cleared", 32'(miso), 32'h40);
    frame_end();
`else
    frame_start();
    send(8'h01, miso, ld, txd, rd);
    send(8'h00, miso, ld, txd, rd);
    frame_end();
    check("ovf_sticky_no_status", 32'(dut.tx_ovf_q), 32'h1);
`endif

    // RX word then empty FIFO
    bus.rx_data = 10'h2A5; bus.rx_empty = 1'b0;
    frame_start();
    send(8'h05, miso, ld, txd, rd);
    check("rx_hi", 32'(miso), 32'h02);
    check("rx_read", 32'(rd), 32'h1);
    exp_reads++;
    bus.rx_empty = 1'b1;
    send(8'h00, miso, ld, txd, rd);
    check("rx_lo", 32'(miso), 32'hA5);
    send(8'h00, miso, ld, txd, rd);
    check("rx_empty_hi", 32'(miso), 32'h80);
    check("rx_empty_no_read", 32'(rd), 32'h0);
    send(8'h00, miso, ld, txd, rd);
    check("rx_empty_lo", 32'(miso), 32'h00);
    frame_end();

    // Error flag reaches the RX high byte
    pulse_error();
    bus.rx_data = 10'h155; bus.rx_empty = 1'b0;
    frame_start();
    send(8'h05, miso, ld, txd, rd);
    check("rx_err_hi", 32'(miso), 32'h41);
    exp_reads++;
    send(8'h00, miso, ld, txd, rd);
    check("rx_err_lo", 32'(miso), 32'h55);
    bus.rx_empty = 1'b1;
    frame_end();

    // Abort mid-word, then a fresh frame
    frame_start();
    send(8'h04, miso, ld, txd, rd);
    send(8'h03, miso, ld, txd, rd);
    frame_end();
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    check("abort_loads", 32'(load_cnt), 32'(exp_loads));
    frame_start();
    send(8'h04, miso, ld, txd, rd);
    send(8'h00, miso, ld, txd, rd);
    send(8'h11, miso, ld, txd, rd);
    check("abort_new_load", 32'(ld), 32'h1);
    check("abort_new_data", 32'(txd), 32'h011);
    exp_loads++;
    frame_end();

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) pulse_error();
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 3);
      frame_start();
      if (kind == 0) begin
        send(8'h04, miso, ld, txd, rd);
        for (int i = 0; i < n; i++) begin
          hi = 8'($urandom); lo = 8'($urandom); full = 1'($urandom);
          send(hi, miso, ld, txd, rd);
          check("rnd_tx_hi_noload", 32'(ld), 32'h0);
          bus.tx_full = full;
          send(lo, miso, ld, txd, rd);
          bus.tx_full = 1'b0;
          check("rnd_tx_load", 32'(ld), 32'(!full));
          if (!full) begin
            check("rnd_tx_data", 32'(txd), (32'(hi) % 4) * 256 + 32'(lo));
            exp_loads++;
          end
        end
      end else if (kind == 1) begin
        for (int i = 0; i < n; i++) begin
          w = DW'($urandom); empty = ($urandom_range(0, 3) == 0);
          bus.rx_data = w; bus.rx_empty = empty;
          send((i == 0) ? 8'h05 : 8'($urandom), miso, ld, txd, rd);
          check("rnd_rx_hi", 32'(miso), empty ? 32'h80 : 32'(exp_hi(w, err_s_m)));
          check("rnd_rx_read", 32'(rd), 32'(!empty));
          if (!empty) exp_reads++;
          bus.rx_data = DW'($urandom); bus.rx_empty = 1'($urandom);
          send(8'($urandom), miso, ld, txd, rd);
          check("rnd_rx_lo", 32'(miso), empty ? 32'h00 : 32'(w % 256));
          check("rnd_rx_lo_noread", 32'(rd), 32'h0);
        end
        bus.rx_empty = 1'b1;
      end else begin
        cb = 8'h04;
        while (cb == 8'h04 || cb == 8'h05 || cb == 8'h01) cb = 8'($urandom);
        bus.rx_empty = 1'b0;
        send(cb, miso, ld, txd, rd);
        for (int i = 0; i < n; i++) begin
          send(8'($urandom), miso, ld, txd, rd);
          check("rnd_discard_quiet", 32'({ld, rd}), 32'h0);
        end
        bus.rx_empty = 1'b1;
      end
      frame_end();
    end
    check("total_loads", 32'(load_cnt), 32'(exp_loads));
    check("total_reads", 32'(read_cnt), 32'(exp_reads));

    // Asynchronous reset in the middle of an RX frame
    bus.rx_data = 10'h3C3; bus.rx_empty = 1'b0;
    frame_start();
    send(8'h05, miso, ld, txd, rd);
    exp_reads++;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("arst_spi_tx_data", 32'(bus.spi_tx_data), 32'h00);
    check("arst_tx_data", 32'(bus.tx_data), 32'h0);
    check("arst_tx_load", 32'(bus.tx_load), 32'h0);
    check("arst_rx_read", 32'(bus.rx_read), 32'h0);
    check("arst_state", 32'(dut.state_q), 32'(IDLE));
    check("arst_err_s", 32'(dut.rx_err_s_q), 32'h0);
    check("arst_ovf", 32'(dut.tx_ovf_q), 32'h0);
    err_s_m = 1'b0;
    bus.spi_cs = 1'b1; bus.rx_empty = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
